// File: rtl/i2s_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_serializer_if
//   Sample-pair handoff between the equalizer datapath and the I2S transmit
//   serializer.
//
//   Handshake: the master presents lft_in/rht_in with vld; the slave raises
//   rdy while it can take a pair. A pair transfers on every rising clk edge
//   where vld & rdy are both 1. The master keeps vld and the data stable
//   until that edge. rdy does not depend on vld.
//
//   Signals:
//     lft_in  [DATA_W] left sample, signed
//     rht_in  [DATA_W] right sample, signed
//     vld     pair valid (master -> slave)
//     rdy     slave can accept a pair (slave -> master)
// ---------------------------------------------------------------------------
interface i2s_serializer_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] lft_in;
    logic [DATA_W-1:0] rht_in;
    logic              vld;
    logic              rdy;

    modport master (output lft_in, output rht_in, output vld, input rdy);
    modport slave  (input lft_in, input rht_in, input vld, output rdy);
endinterface

// File: rtl/i2s_serializer.sv
// ---------------------------------------------------------------------------
// i2s_serializer
//   Transmit half of the codec audio path. Takes left/right sample pairs
//   through a one-pair holding buffer and shifts them out MSB first on SDin
//   in standard I2S framing (MSB one SCLK after each LRCLK edge), slaved to
//   the external LRCLK / SCLK-fall strobe.
//
//   Ports:
//     clk        system clock, rising edge
//     RST_n      synchronous active-low reset
//     sclk_fall  one-clk strobe in the cycle before each SCLK falling edge
//     LRCLK      frame clock level (0 = left slot, 1 = right slot)
//     smp        sample-pair handoff (slave side: lft_in, rht_in, vld, rdy)
//     SDin       registered serial data to the codec
//     undrn      one-clk pulse: left slot started with no pair buffered
//     fr_err     one-clk pulse: slot ended before all DATA_W bits were sent
//     dbg_state  current FSM state (SYNC=0, LEFT=1, RIGHT=2)
//
//   Build option I2S_TX_UNDERRUN_ZERO_EN:
//     defined   - an underrun frame transmits zeros on both channels
//     undefined - an underrun frame repeats the last transmitted pair
// ---------------------------------------------------------------------------
module i2s_serializer #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              sclk_fall,
    input  logic              LRCLK,
    i2s_serializer_if.slave   smp,
    output logic              SDin,
    output logic              undrn,
    output logic              fr_err,
    output logic [1:0]        dbg_state
);

    localparam int                CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  BIT_MAX = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              lr_q;
    logic              full;
    logic [DATA_W-1:0] lft_buf, rht_buf;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rht_hold;
    logic [CNT_W-1:0]  bit_cnt;
`ifndef I2S_TX_UNDERRUN_ZERO_EN
    logic [DATA_W-1:0] last_lft, last_rht;
`endif

    logic              slot_chg;
    logic              left_load, right_load;
    logic              accept;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] hold_next;
    logic              undrn_next, fr_err_next;

    assign smp.rdy   = ~full;
    assign accept    = smp.vld & ~full;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!RST_n) state <= ST_SYNC;
        else        state <= state_next;
    end

    // Next state, slot-load decisions and the word to load.
    always_comb begin
        state_next  = state;
        left_load   = 1'b0;
        right_load  = 1'b0;
        load_word   = rht_hold;
        hold_next   = rht_hold;
        // lr_q still holds the LRCLK level seen at the previous SCLK fall.
        slot_chg    = sclk_fall && (LRCLK != lr_q);

        unique case (state)
            ST_SYNC: begin
                // Only a falling LRCLK edge marks a frame start; wait for it.
                if (slot_chg && !LRCLK) begin
                    state_next = ST_LEFT;
                    left_load  = 1'b1;
                end
            end
            ST_LEFT: begin
                if (slot_chg && LRCLK) begin
                    state_next = ST_RIGHT;
                    right_load = 1'b1;
                end
            end
            ST_RIGHT: begin
                if (slot_chg && !LRCLK) begin
                    state_next = ST_LEFT;
                    left_load  = 1'b1;
                end
            end
            default: state_next = ST_SYNC;
        endcase

        if (left_load) begin
            if (full) begin
                load_word = lft_buf;
                hold_next = rht_buf;
            end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                load_word = '0;
                hold_next = '0;
`else
                load_word = last_lft;
                hold_next = last_rht;
`endif
            end
        end

        undrn_next  = left_load && !full;
        // The first load out of SYNC has no previous word to cut short.
        fr_err_next = (left_load || right_load) && (state != ST_SYNC) &&
                      (bit_cnt < BIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            lr_q      <= 1'b1;
            full      <= 1'b0;
            lft_buf   <= '0;
            rht_buf   <= '0;
            shift_reg <= '0;
            rht_hold  <= '0;
            bit_cnt   <= '0;
            SDin      <= 1'b0;
            undrn     <= 1'b0;
            fr_err    <= 1'b0;
`ifndef I2S_TX_UNDERRUN_ZERO_EN
            last_lft  <= '0;
            last_rht  <= '0;
`endif
        end else begin
            undrn  <= undrn_next;
            fr_err <= fr_err_next;

            if (sclk_fall) lr_q <= LRCLK;

            // accept implies !full, so it never collides with the left-slot
            // drain; a pair arriving on an underrun slot start is kept for
            // the next frame.
            if (accept) begin
                full    <= 1'b1;
                lft_buf <= smp.lft_in;
                rht_buf <= smp.rht_in;
            end else if (left_load && full) begin
                full    <= 1'b0;
            end

            if (left_load) rht_hold <= hold_next;

`ifndef I2S_TX_UNDERRUN_ZERO_EN
            if (left_load && full) begin
                last_lft <= lft_buf;
                last_rht <= rht_buf;
            end
`endif

            if (left_load || right_load) begin
                // MSB goes straight out on the slot-start SCLK fall.
                SDin      <= load_word[DATA_W-1];
                shift_reg <= load_word << 1;
                bit_cnt   <= CNT_W'(1);
            end else if (sclk_fall && state != ST_SYNC) begin
                if (bit_cnt < BIT_MAX) begin
                    SDin      <= shift_reg[DATA_W-1];
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end else begin
                    SDin      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_serializer
//   Bench for i2s_serializer: an LRCLK/SCLK-strobe generator, a frame-level
//   reference model (pair buffer, frame pair, last pair), an I2S receiver that
//   rebuilds each slot from SDin, and a scoreboard of expected slot words.
// ---------------------------------------------------------------------------
module tb_i2s_serializer;

    localparam int DATA_W   = 24;
    localparam int SLOT_LEN = 32;
    localparam int SHORT_LEN = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sclk_fall = 1'b0;
    logic       lrclk     = 1'b1;
    logic       sdin, undrn, fr_err;
    logic [1:0] dbg_state;

    i2s_serializer_if #(.DATA_W(DATA_W)) bus ();

    i2s_serializer #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .RST_n     (rst_n),
        .sclk_fall (sclk_fall),
        .LRCLK     (lrclk),
        .smp       (bus.slave),
        .SDin      (sdin),
        .undrn     (undrn),
        .fr_err    (fr_err),
        .dbg_state (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- frame clock generator ----------------
    // sclk_fall every 8 clk; LRCLK toggles after cur_len SCLK falls.
    int div_cnt    = 0;
    int edge_cnt   = 0;
    int cur_len    = SLOT_LEN;
    bit short_next = 1'b0;

    always @(negedge clk) begin
        if (sclk_fall) begin
            edge_cnt++;
            if (edge_cnt >= cur_len) begin
                lrclk    = ~lrclk;
                edge_cnt = 0;
                if (!lrclk && short_next) begin
                    cur_len    = SHORT_LEN;
                    short_next = 1'b0;
                end else begin
                    cur_len = SLOT_LEN;
                end
            end
        end
        div_cnt   = (div_cnt + 1) % 8;
        sclk_fall = (div_cnt == 7);
    end

    // ---------------- reference model (evaluated on each clk edge) ----------
    logic [DATA_W-1:0] exp_q[$];
    int                cyc = 0;
    bit                m_full, m_synced, m_lr, m_rst;
    bit                m_edge, m_start, m_start_left;
    bit                m_exp_undrn, m_exp_fr;
    int                m_since;
    int                m_left_starts = 0;
    int                m_left_cyc = 0;
    logic [DATA_W-1:0] m_pend_l, m_pend_r, m_last_l, m_last_r, m_cur_r;
    logic [DATA_W-1:0] f_l, f_r;

    always @(posedge clk) begin
        bit accepted;
        cyc++;
        m_edge = 0; m_start = 0; m_start_left = 0;
        m_exp_undrn = 0; m_exp_fr = 0;
        if (!rst_n) begin
            m_rst = 1; m_full = 0; m_synced = 0; m_lr = 1; m_since = 0;
            m_last_l = '0; m_last_r = '0; m_cur_r = '0;
            exp_q.delete();
        end else begin
            m_rst    = 0;
            accepted = bus.vld && !m_full;
            if (sclk_fall) begin
                m_edge = 1;
                if (lrclk != m_lr && !lrclk) begin
                    // frame start: take the buffered pair or fall back
                    if (m_synced && m_since < DATA_W) m_exp_fr = 1;
                    m_synced = 1;
                    if (m_full) begin
                        f_l = m_pend_l; f_r = m_pend_r;
                        m_last_l = m_pend_l; m_last_r = m_pend_r;
                        m_full = 0;
                    end else begin
                        m_exp_undrn = 1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                        f_l = '0; f_r = '0;
`else
                        f_l = m_last_l; f_r = m_last_r;
`endif
                    end
                    m_cur_r = f_r;
                    exp_q.push_back(f_l);
                    m_start = 1; m_start_left = 1; m_since = 1;
                    m_left_starts++;
                    m_left_cyc = cyc;
                end else if (lrclk != m_lr && m_synced) begin
                    if (m_since < DATA_W) m_exp_fr = 1;
                    exp_q.push_back(m_cur_r);
                    m_start = 1; m_since = 1;
                end else if (m_synced) begin
                    m_since++;
                end
                m_lr = lrclk;
            end
            if (accepted) begin
                m_full = 1; m_pend_l = bus.lft_in; m_pend_r = bus.rht_in;
            end
        end
    end

    // ---------------- receiver / scoreboard ----------------
    bit                rx_on = 0, rx_is_left = 0;
    int                rx_n = 0, rx_pad = 0;
    logic [DATA_W-1:0] rx_word, rx_last_l = '0, rx_last_r = '0;
    int                undrn_cnt = 0, fr_cnt = 0;

    task automatic close_slot();
        logic [DATA_W-1:0] exp_w, mask;
        int n;
        check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n     = (rx_n < DATA_W) ? rx_n : DATA_W;
            mask  = {DATA_W{1'b1}} << (DATA_W - n);
            check(rx_is_left ? "slot_word_l" : "slot_word_r", 32'(rx_word), 32'(exp_w & mask));
            check("slot_pad", 32'(rx_pad), 32'd0);
            if (rx_is_left) rx_last_l = rx_word;
            else            rx_last_r = rx_word;
        end
    endtask

    always @(negedge clk) begin
        check("rdy", 32'(bus.rdy), 32'(!m_full));
        check("undrn", 32'(undrn), 32'(m_exp_undrn));
        check("fr_err", 32'(fr_err), 32'(m_exp_fr));
        if (undrn === 1'b1)  undrn_cnt++;
        if (fr_err === 1'b1) fr_cnt++;
        if (m_rst || !m_synced) begin
            rx_on = 0;
            check("sdin_idle", 32'(sdin), 32'd0);
        end else if (m_edge) begin
            if (m_start) begin
                if (rx_on) close_slot();
                rx_on = 1; rx_n = 0; rx_pad = 0; rx_word = '0;
                rx_is_left = m_start_left;
            end
            if (rx_on) begin
                if (rx_n < DATA_W) rx_word[DATA_W-1-rx_n] = sdin;
                else               rx_pad += int'(sdin);
                rx_n++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;
    int waited  = 0;

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int n = 0;
        bus.lft_in = l;
        bus.rht_in = r;
        bus.vld    = 1'b1;
        while (bus.rdy !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("push_in_time", 32'(n < 3000), 32'd1);
        waited  = n;
        acc_cyc = cyc + 1;
        @(negedge clk);
        bus.vld = 1'b0;
    endtask

    task automatic wait_left();
        int start = m_left_starts;
        int n = 0;
        while (m_left_starts == start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("left_start_in_time", 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    localparam logic [DATA_W-1:0] U_L = 24'h123456;
    localparam logic [DATA_W-1:0] U_R = 24'hFEDCBA;

    initial begin
        logic [DATA_W-1:0] s_l, s_r, exp_ul, exp_ur;
        int u0, f0;

        rst_n = 1'b0; bus.vld = 1'b0; bus.lft_in = '0; bus.rht_in = '0;
        repeat (20) @(negedge clk);
        check("rst_rdy", 32'(bus.rdy), 32'd1);
        check("rst_sdin", 32'(sdin), 32'd0);
        rst_n = 1'b1;

        // basic frame, then back-to-back pairs
        push_pair(24'hA5A5A5, 24'h3C3C3C);
        wait_left();
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        check("bp_waited", 32'(waited > 0), 32'd1);
        check("bp_rdy_delay", 32'(acc_cyc - m_left_cyc), 32'd1);
        @(negedge clk);
        check("basic_left", 32'(rx_last_l), 32'hA5A5A5);
        check("basic_right", 32'(rx_last_r), 32'h3C3C3C);
        check("basic_no_undrn", 32'(undrn_cnt), 32'd0);
        check("basic_no_fr_err", 32'(fr_cnt), 32'd0);
        wait_left();
        check("bp_p1_left", 32'(rx_last_l), 32'h111111);
        check("bp_p1_right", 32'(rx_last_r), 32'h222222);

        // underrun: one pair, then a frame with nothing buffered
        push_pair(U_L, U_R);
        wait_left();
        check("p2_left", 32'(rx_last_l), 32'h333333);
        u0 = undrn_cnt;
        wait_left();
        s_l = DATA_W'($urandom); s_r = DATA_W'($urandom);
        push_pair(s_l, s_r);
        short_next = 1'b1;
        wait_left();
        @(negedge clk);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        exp_ul = '0; exp_ur = '0;
`else
        exp_ul = U_L; exp_ur = U_R;
`endif
        check("undrn_once", 32'(undrn_cnt - u0), 32'd1);
        check("undrn_left", 32'(rx_last_l), 32'(exp_ul));
        check("undrn_right", 32'(rx_last_r), 32'(exp_ur));

        // short left slot (10 bits), right word must be intact
        f0 = fr_cnt;
        push_pair(24'h0F0F0F, 24'h7E7E7E);
        wait_left();
        check("short_fr_err", 32'(fr_cnt - f0), 32'd1);
        check("short_left", 32'(rx_last_l), 32'(s_l & 24'hFFC000));
        check("short_right", 32'(rx_last_r), 32'(s_r));

        // mid-word reset around bit 12 of a left word
        repeat (12 * 8 - 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sdin", 32'(sdin), 32'd0);
        check("midrst_rdy", 32'(bus.rdy), 32'd1);
        check("midrst_undrn", 32'(undrn), 32'd0);
        rst_n = 1'b1;

        // randomized traffic with random gaps
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 900)) @(negedge clk);
            push_pair(DATA_W'($urandom), DATA_W'($urandom));
        end
        wait_left();
        wait_left();
        wait_left();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
